// File: rtl/ysyx_24100005_ifu_sram.sv
// Fetch-port instruction memory: one outstanding PC fetch, fixed latency,
// valid/ready response, plus a back-door word loader for program images.
module ysyx_24100005_ifu_sram #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          LATENCY   = 1,
  localparam int         AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_inst,
  output logic          rsp_err,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  output logic          busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic [32:0] LO_LIM   = {1'b0, ADDR_BASE};
  localparam logic [32:0] HI_LIM   = LO_LIM + 33'(4 * DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [31:0]   inst_q;
  logic          err_q;

  logic          accept;
  logic          err_c;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic [32:0]   addr_x;
  logic          unused_off;

  // Range check is done in 33 bits so addresses near 2^32 cannot wrap in.
  assign addr_x = {1'b0, req_addr};
  assign err_c  = (|req_addr[1:0])
                | (addr_x < LO_LIM)
                | (addr_x >= HI_LIM);

  assign off        = req_addr - ADDR_BASE;
  assign idx        = off[AW+1:2];
  assign unused_off = ^{off[31:AW+2], off[1:0]};

  assign req_ready = rst & (state == S_IDLE);
  assign accept    = req_valid & req_ready;
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);
  assign rsp_inst  = inst_q;
  assign rsp_err   = err_q;

  // Array is deliberately not reset so a preloaded image survives rst.
  always_ff @(posedge clk) begin
    if (rst && ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      inst_q <= 32'h0;
      err_q  <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (accept) begin
            err_q  <= err_c;
            inst_q <= err_c ? 32'h0 : mem[idx];
            cnt    <= CNT_INIT;
            state  <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        (state == S_WAIT): begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= S_RESP;
          end
        end
        (state == S_RESP): begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_ifu_sram.sv
// Directed bench: one responder with LATENCY=1 and one with LATENCY=4,
// expected words and timings written out by hand.
module tb_ysyx_24100005_ifu_sram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] PROG [8] = '{
    32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213,
    32'h0050_0293, 32'h0060_0313, 32'h0070_0393, 32'h0080_0413
  };

  logic        a_rst, a_req_valid, a_req_ready, a_rsp_valid;
  logic        a_rsp_ready, a_rsp_err, a_ld_en, a_busy;
  logic [31:0] a_req_addr, a_rsp_inst, a_ld_data;
  logic [11:0] a_ld_addr;

  logic        b_rst, b_req_valid, b_req_ready, b_rsp_valid;
  logic        b_rsp_ready, b_rsp_err, b_ld_en, b_busy;
  logic [31:0] b_req_addr, b_rsp_inst, b_ld_data;
  logic [11:0] b_ld_addr;

  ysyx_24100005_ifu_sram #(.LATENCY(1)) u_a (
    .clk(clk), .rst(a_rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_addr(a_req_addr),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_inst(a_rsp_inst), .rsp_err(a_rsp_err),
    .ld_en(a_ld_en), .ld_addr(a_ld_addr), .ld_data(a_ld_data),
    .busy(a_busy)
  );

  ysyx_24100005_ifu_sram #(.LATENCY(4)) u_b (
    .clk(clk), .rst(b_rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_addr(b_req_addr),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_inst(b_rsp_inst), .rsp_err(b_rsp_err),
    .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data),
    .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic a_load(input logic [11:0] i, input logic [31:0] d);
    @(negedge clk);
    a_ld_en = 1'b1; a_ld_addr = i; a_ld_data = d;
    @(negedge clk);
    a_ld_en = 1'b0;
  endtask

  task automatic b_load(input logic [11:0] i, input logic [31:0] d);
    @(negedge clk);
    b_ld_en = 1'b1; b_ld_addr = i; b_ld_data = d;
    @(negedge clk);
    b_ld_en = 1'b0;
  endtask

  task automatic a_fetch(input string tag, input logic [31:0] addr,
                         input logic [31:0] inst, input logic err);
    @(negedge clk);
    chk({tag, ".rdy"}, a_req_ready, 1);
    a_req_valid = 1'b1; a_req_addr = addr; a_rsp_ready = 1'b1;
    @(negedge clk);
    a_req_valid = 1'b0;
    chk({tag, ".vld"}, a_rsp_valid, 1);
    chk({tag, ".inst"}, a_rsp_inst, inst);
    chk({tag, ".err"}, a_rsp_err, err);
    @(negedge clk);
  endtask

  task automatic b_fetch(input string tag, input logic [31:0] addr,
                         input logic [31:0] inst, input logic err);
    int n;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_addr = addr; b_rsp_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      b_req_valid = 1'b0;
      n++;
    end while (!b_rsp_valid && n < 20);
    chk({tag, ".lat"}, n, 4);
    chk({tag, ".inst"}, b_rsp_inst, inst);
    chk({tag, ".err"}, b_rsp_err, err);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int last;
    a_rst = 0; a_req_valid = 0; a_req_addr = 0; a_rsp_ready = 0;
    a_ld_en = 0; a_ld_addr = 0; a_ld_data = 0;
    b_rst = 0; b_req_valid = 0; b_req_addr = 0; b_rsp_ready = 0;
    b_ld_en = 0; b_ld_addr = 0; b_ld_data = 0;
    repeat (2) @(negedge clk);

    chk("rst.rdy", a_req_ready, 0);
    chk("rst.vld", a_rsp_valid, 0);
    chk("rst.busy", a_busy, 0);
    chk("rst.inst", a_rsp_inst, 0);
    chk("rst.err", a_rsp_err, 0);
    chk("rst.b_rdy", b_req_ready, 0);
    a_rst = 1; b_rst = 1;
    #1 chk("rel.rdy", a_req_ready, 1);

    for (int i = 0; i < 8; i++) a_load(12'(i), PROG[i]);
    a_load(12'd4095, 32'hDEAD_BEEF);
    b_load(12'd1, 32'h1111_1111);
    b_load(12'd2, 32'h2222_2222);
    b_load(12'd3, 32'h3333_3333);

    // Basic fetch, LATENCY=1
    @(negedge clk);
    a_req_valid = 1; a_req_addr = 32'h8000_0000; a_rsp_ready = 0;
    @(negedge clk);
    a_req_valid = 0;
    chk("t1.vld", a_rsp_valid, 1);
    chk("t1.inst", a_rsp_inst, 32'h0010_0093);
    chk("t1.err", a_rsp_err, 0);
    chk("t1.rdy_lo", a_req_ready, 0);
    chk("t1.busy", a_busy, 1);
    a_rsp_ready = 1;
    @(negedge clk);
    chk("t1.rdy_hi", a_req_ready, 1);
    chk("t1.vld_lo", a_rsp_valid, 0);

    // Error cases and last in-range word
    a_fetch("e.mis", 32'h8000_0002, 32'h0, 1);
    a_fetch("e.low", 32'h7FFF_FFFC, 32'h0, 1);
    a_fetch("e.top", 32'h8000_4000, 32'h0, 1);
    a_fetch("e.wrap", 32'hFFFF_FFFC, 32'h0, 1);
    a_fetch("e.last", 32'h8000_3FFC, 32'hDEAD_BEEF, 0);

    // Sequential stream, one response every 2 cycles
    a_rsp_ready = 1;
    @(negedge clk);
    last = 0;
    for (int i = 0; i < 8; i++) begin
      chk("s.rdy", a_req_ready, 1);
      a_req_valid = 1;
      a_req_addr = 32'h8000_0000 + 32'(4 * i);
      @(negedge clk);
      chk("s.vld", a_rsp_valid, 1);
      chk("s.inst", a_rsp_inst, PROG[i]);
      if (i > 0) chk("s.gap", cyc - last, 2);
      last = cyc;
      @(negedge clk);
    end
    a_req_valid = 0;

    // Same-cycle write: old word returned, refetch sees new word
    @(negedge clk);
    a_req_valid = 1; a_req_addr = 32'h8000_0014; a_rsp_ready = 1;
    a_ld_en = 1; a_ld_addr = 12'd5; a_ld_data = 32'hBBBB_0005;
    @(negedge clk);
    a_req_valid = 0; a_ld_en = 0;
    chk("h.vld", a_rsp_valid, 1);
    chk("h.old", a_rsp_inst, PROG[5]);
    @(negedge clk);
    a_fetch("h.new", 32'h8000_0014, 32'hBBBB_0005, 0);

    // LATENCY=4 with back-pressure and a held second request
    @(negedge clk);
    b_rsp_ready = 0; b_req_valid = 1; b_req_addr = 32'h8000_0004;
    @(negedge clk);
    b_req_addr = 32'h8000_0008;
    chk("l4.busy", b_busy, 1);
    chk("l4.rdy", b_req_ready, 0);
    chk("l4.v1", b_rsp_valid, 0);
    @(negedge clk);
    chk("l4.v2", b_rsp_valid, 0);
    @(negedge clk);
    chk("l4.v3", b_rsp_valid, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("l4.vld", b_rsp_valid, 1);
      chk("l4.inst", b_rsp_inst, 32'h1111_1111);
      chk("l4.err", b_rsp_err, 0);
      chk("l4.rdy_hold", b_req_ready, 0);
    end
    b_rsp_ready = 1;
    @(negedge clk);
    chk("l4.idle_vld", b_rsp_valid, 0);
    chk("l4.idle_rdy", b_req_ready, 1);
    @(negedge clk);
    b_req_valid = 0;
    chk("l4.second_busy", b_busy, 1);
    repeat (3) @(negedge clk);
    chk("l4.second_vld", b_rsp_valid, 1);
    chk("l4.second_inst", b_rsp_inst, 32'h2222_2222);
    @(negedge clk);
    chk("l4.done", b_busy, 0);

    // Write during pending fetch does not disturb the response
    @(negedge clk);
    b_req_valid = 1; b_req_addr = 32'h8000_0008;
    @(negedge clk);
    b_req_valid = 0;
    b_ld_en = 1; b_ld_addr = 12'd2; b_ld_data = 32'h2222_AAAA;
    @(negedge clk);
    b_ld_en = 0;
    repeat (2) @(negedge clk);
    chk("p.vld", b_rsp_valid, 1);
    chk("p.old", b_rsp_inst, 32'h2222_2222);
    @(negedge clk);
    b_fetch("p.new", 32'h8000_0008, 32'h2222_AAAA, 0);

    // Reset in WAIT: drop request, keep memory, ignore loads
    @(negedge clk);
    b_req_valid = 1; b_req_addr = 32'h8000_000C;
    @(negedge clk);
    b_req_valid = 0;
    @(negedge clk);
    chk("r.busy_pre", b_busy, 1);
    b_rst = 0;
    b_ld_en = 1; b_ld_addr = 12'd3; b_ld_data = 32'h0BAD_0BAD;
    #1;
    chk("r.vld", b_rsp_valid, 0);
    chk("r.rdy", b_req_ready, 0);
    chk("r.busy", b_busy, 0);
    chk("r.inst", b_rsp_inst, 0);
    @(negedge clk);
    b_ld_en = 0; b_rst = 1;
    #1 chk("r.rel_rdy", b_req_ready, 1);
    b_fetch("r.mem", 32'h8000_000C, 32'h3333_3333, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
